// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle controller and datapath/memory.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;
  logic       bus_err;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op, bus_err, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op, bus_err, state
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM with a ready/timeout memory handshake.
module mc_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);
  localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_access;
  logic             w_timeout;
  logic             w_illegal;
  logic             w_funct_ok;
  logic [2:0]       w_alu_funct;

  logic       r_mem_req;
  logic       r_iord;
  logic       r_memwrite;
  logic       r_regwrite;
  logic       r_regdst;
  logic       r_memtoreg;
  logic       r_alusrca;
  logic [1:0] r_alusrcb;
  logic [1:0] r_pcsrc;
  logic [2:0] r_alucontrol;

  // R-type funct decode into ALU opcode
  always_comb begin
    w_funct_ok  = 1'b1;
    w_alu_funct = 3'b010;
    case (bus.funct)
      6'b100000: w_alu_funct = 3'b010;
      6'b100010: w_alu_funct = 3'b110;
      6'b100100: w_alu_funct = 3'b000;
      6'b100101: w_alu_funct = 3'b001;
      6'b101010: w_alu_funct = 3'b111;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  // Memory-access states share one wait counter; ready in the abort cycle still completes
  assign w_access  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout = (MEM_TIMEOUT != 0) && w_access && !bus.mem_ready &&
                     (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Next-state selection and illegal-instruction detection
  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_ready)  w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_MEMWR: begin
        if (bus.mem_ready || w_timeout) w_next = S_FETCH;
      end
      S_EXEC: begin
        if (w_funct_ok) begin
          w_next = S_ALUWB;
        end else begin
          w_next    = S_FETCH;
          w_illegal = 1'b1;
        end
      end
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // State, wait counter, and the Moore outputs of the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= '0;
      r_mem_req    <= 1'b1;
      r_iord       <= 1'b0;
      r_memwrite   <= 1'b0;
      r_regwrite   <= 1'b0;
      r_regdst     <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_alusrca    <= 1'b0;
      r_alusrcb    <= 2'b01;
      r_pcsrc      <= 2'b00;
      r_alucontrol <= 3'b010;
    end else begin
      r_state <= w_next;
      if (w_access && !bus.mem_ready && !w_timeout) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      else                                           r_wait_cnt <= '0;

      r_mem_req    <= 1'b0;
      r_iord       <= 1'b0;
      r_memwrite   <= 1'b0;
      r_regwrite   <= 1'b0;
      r_regdst     <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_alusrca    <= 1'b0;
      r_alusrcb    <= 2'b00;
      r_pcsrc      <= 2'b00;
      r_alucontrol <= 3'b010;
      case (w_next)
        S_FETCH: begin
          r_mem_req <= 1'b1;
          r_alusrcb <= 2'b01;
        end
        S_DECODE: r_alusrcb <= 2'b11;
        S_MEMADR: begin
          r_alusrca <= 1'b1;
          r_alusrcb <= 2'b10;
        end
        S_MEMRD: begin
          r_mem_req <= 1'b1;
          r_iord    <= 1'b1;
        end
        S_MEMWB: begin
          r_regwrite <= 1'b1;
          r_memtoreg <= 1'b1;
        end
        S_MEMWR: begin
          r_mem_req  <= 1'b1;
          r_iord     <= 1'b1;
          r_memwrite <= 1'b1;
        end
        S_EXEC: r_alusrca <= 1'b1;
        S_ALUWB: begin
          r_regwrite <= 1'b1;
          r_regdst   <= 1'b1;
        end
        S_BRANCH: begin
          r_alusrca    <= 1'b1;
          r_alucontrol <= 3'b110;
          r_pcsrc      <= 2'b01;
        end
        S_ADDIEX: begin
          r_alusrca <= 1'b1;
          r_alusrcb <= 2'b10;
        end
        S_ADDIWB: r_regwrite <= 1'b1;
        S_JUMP:   r_pcsrc    <= 2'b10;
        default: ;
      endcase
    end
  end

  assign bus.mem_req    = r_mem_req;
  assign bus.iord       = r_iord;
  assign bus.memwrite   = r_memwrite;
  assign bus.regwrite   = r_regwrite;
  assign bus.regdst     = r_regdst;
  assign bus.memtoreg   = r_memtoreg;
  assign bus.alusrca    = r_alusrca;
  assign bus.alusrcb    = r_alusrcb;
  assign bus.pcsrc      = r_pcsrc;
  assign bus.alucontrol = (r_state == S_EXEC) ? w_alu_funct : r_alucontrol;
  assign bus.state      = r_state;

  // Handshake-qualified strobes and pulses, forced low while reset is held
  assign bus.irwrite    = reset && (r_state == S_FETCH) && bus.mem_ready;
  assign bus.pcen       = reset && (((r_state == S_FETCH) && bus.mem_ready) ||
                                    (r_state == S_JUMP) ||
                                    ((r_state == S_BRANCH) && bus.zero));
  assign bus.illegal_op = reset && w_illegal;
  assign bus.bus_err    = reset && w_timeout;
endmodule
